ice_bridge: RTL and testbench
=============================

ICE_BRIDGE -- requirements
Module: ice_bridge

Interface
REQ-001 Parameter AW, default 16, bus address width; multiple of 4, range 4..32.
REQ-002 Parameter DW, default 16, bus data width; multiple of 4, range 4..32.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for BUS_ACK; range 1..65535.
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 RX_DATA  in  8  command byte; RX_VALID in 1 byte strobe; RX_READY out 1 block accepts byte.
REQ-007 TX_DATA  out  8  response byte; TX_VALID out 1; TX_READY in 1 downstream accepts.
REQ-008 BUS_REQ out 1; BUS_WE out 1; BUS_ADDR out AW; BUS_WDATA out DW; BUS_ACK in 1; BUS_RDATA in DW.
REQ-009 CORE_RESET out 1; CORE_STATE out 2; PC_LOAD out 1 one-cycle pulse; PC_VALUE out DW (= data register); CORE_PC in DW.
REQ-010 STAT_OVR out 1, sticky overrun flag.

Function
REQ-011 Byte decode: cmd = RX_DATA[7:4], nib = RX_DATA[3:0]; byte accepted only on cycle with RX_VALID=1 and RX_READY=1.
REQ-012 RX_READY SHALL be 1 only in state IDLE; RX_VALID=1 while RX_READY=0 drops the byte and sets STAT_OVR.
REQ-013 States: IDLE, BUS, TX_ACK, TX_DATA.
REQ-014 cmd 0x0: addr <= {addr[AW-5:0], nib}; stay IDLE, no response.
REQ-015 cmd 0x1: data <= {data[DW-5:0], nib}; stay IDLE, no response.
REQ-016 cmd 0x2: addr <= 0, data <= 0; no response.
REQ-017 cmd 0x8: write; next cycle BUS_REQ=1, BUS_WE=1, BUS_ADDR=addr, BUS_WDATA=data; state BUS.
REQ-018 cmd 0x9: read; next cycle BUS_REQ=1, BUS_WE=0, BUS_ADDR=addr; state BUS.
REQ-019 In BUS: BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA held stable until BUS_ACK=1 or timeout.
REQ-020 BUS_ACK=1 in BUS: BUS_REQ drops next cycle; read captures BUS_RDATA into data; if nib[0]=1, addr <= addr+1 modulo 2^AW.
REQ-021 Write success -> TX_ACK emitting 0xA0; read success -> TX_DATA.
REQ-022 Timeout: counter cleared on BUS entry; after TIMEOUT cycles with BUS_ACK=0, BUS_REQ drops, addr/data unchanged, TX_ACK emitting 0xE1.
REQ-023 BUS_ACK outside BUS is ignored.
REQ-024 cmd 0xA: TX_DATA without bus access (reports data register).
REQ-025 TX_DATA emits DW/4 bytes {4'h5, nibble}, most significant nibble first, then IDLE.
REQ-026 cmd 0xB by nib: 0 CORE_RESET<=0; 1 CORE_RESET<=1; 2/3/4 CORE_STATE<=0/1/2; 5 PC_LOAD pulse one cycle; 6 data<=CORE_PC; 7 STAT_OVR<=0; others no effect; no response.
REQ-027 Any other cmd -> TX_ACK emitting 0xE0; no other state change.
REQ-028 TX handshake: TX_VALID and TX_DATA held stable until cycle with TX_READY=1; byte transferred that cycle; next byte or IDLE the following cycle.
REQ-029 TX_READY low indefinitely stalls; no byte lost or repeated.
REQ-030 Byte to IDLE latency: first TX_VALID or BUS_REQ asserted on the cycle after acceptance.
REQ-031 STAT_OVR set and clear (cmd 0xB,7) on same cycle: set wins.

Reset
REQ-032 RST_N=0 asynchronously forces: state IDLE, addr=0, data=0, CORE_RESET=1, CORE_STATE=0, PC_LOAD=0, BUS_REQ=0, BUS_WE=0, TX_VALID=0, TX_DATA=0, STAT_OVR=0, timeout counter=0.
REQ-033 Reset mid-bus or mid-transmit aborts immediately; no residual BUS_REQ or TX_VALID after release.
REQ-034 RX_READY=1 first cycle after RST_N deasserts.

Verification
REQ-035 Bytes 0x01,0x02,0x03,0x04,0x1B,0x1E,0x1E,0x1F,0x80, ACK after 3 cycles -> BUS_ADDR=0x1234, BUS_WDATA=0xBEEF, BUS_WE=1, TX byte 0xA0.
REQ-036 addr=0xFFFF, byte 0x91, BUS_RDATA=0xCAFE -> TX 0x5C,0x5A,0x5F,0x5E in order; addr wraps to 0x0000.
REQ-037 Byte 0x80, BUS_ACK never -> BUS_REQ high exactly 255 cycles, TX 0xE1, addr/data unchanged.
REQ-038 Bytes 0xB0, 0xB4, 0x11, 0xB5 -> CORE_RESET=0, CORE_STATE=2, PC_LOAD one cycle with PC_VALUE=0x0001; byte 0x70 -> TX 0xE0.
REQ-039 Byte 0xA0 with TX_READY=0 for 10 cycles plus RX byte during stall -> TX_DATA stable, STAT_OVR=1; 0xB7 later clears it.
REQ-040 RST_N pulsed low mid-read -> BUS_REQ=0, TX_VALID=0, CORE_RESET=1 immediately; RX_READY=1 after release.

Source files
------------

// File: rtl/ice_bridge_if.sv
// Byte-stream and bus-master signal bundle for the ICE bridge.
// The master modport is the bridge side. The slave modport is the host/bus side.
interface ice_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_ack, bus_rdata,
    output rx_ready, tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_ack, bus_rdata,
    input  rx_ready, tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/ice_bridge.sv
// ICE bridge: decodes nibble commands from a byte stream into bus cycles and core controls.
// Responses go out as acknowledge bytes or as nibble-per-byte dumps of the data register.
module ice_bridge #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   ice_bridge_if.master  bus_if,
   output logic          core_reset,
   output logic [1:0]    core_state,
   output logic          pc_load,
   output logic [DW-1:0] pc_value,
   input  logic [DW-1:0] core_pc,
   output logic          stat_ovr
);

   typedef enum logic [1:0] {IDLE, BUS, TX_ACK, TX_DATA} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [3:0]  LAST_NIB = 4'(DW / 4 - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          we;
   logic          inc;
   logic [15:0]   tmo_cnt;
   logic [7:0]    ack_byte;
   logic [3:0]    byte_idx;

   logic [3:0]    cmd, nib, nib_sel;
   logic [DW-1:0] shifted;
   logic          accept, timed_out, tx_last;

   assign cmd       = bus_if.rx_data[7:4];
   assign nib       = bus_if.rx_data[3:0];
   assign accept    = bus_if.rx_valid && (state == IDLE);
   assign timed_out = (state == BUS) && !bus_if.bus_ack && (tmo_cnt == TMO_LAST);
   assign tx_last   = (byte_idx == LAST_NIB);
   assign nib_sel   = LAST_NIB - byte_idx;
   assign shifted   = data >> {nib_sel, 2'b00};
   assign pc_value  = data;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) begin
            case (cmd)
               4'h0, 4'h1, 4'h2, 4'hB: state_nxt = IDLE;
               4'h8, 4'h9:             state_nxt = BUS;
               4'hA:                   state_nxt = TX_DATA;
               default:                state_nxt = TX_ACK;
            endcase
         end
         BUS: begin
            if (bus_if.bus_ack) state_nxt = we ? TX_ACK : TX_DATA;
            else if (timed_out) state_nxt = TX_ACK;
         end
         TX_ACK:  if (bus_if.tx_ready) state_nxt = IDLE;
         TX_DATA: if (bus_if.tx_ready && tx_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus_if.rx_ready  = (state == IDLE);
      bus_if.bus_req   = (state == BUS);
      bus_if.bus_we    = (state == BUS) && we;
      bus_if.bus_addr  = addr;
      bus_if.bus_wdata = data;
      bus_if.tx_valid  = 1'b0;
      bus_if.tx_data   = 8'h00;
      case (state)
         TX_ACK: begin
            bus_if.tx_valid = 1'b1;
            bus_if.tx_data  = ack_byte;
         end
         TX_DATA: begin
            bus_if.tx_valid = 1'b1;
            bus_if.tx_data  = {4'h5, shifted[3:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         data       <= '0;
         we         <= 1'b0;
         inc        <= 1'b0;
         tmo_cnt    <= '0;
         ack_byte   <= 8'h00;
         byte_idx   <= '0;
         core_reset <= 1'b1;
         core_state <= 2'd0;
         pc_load    <= 1'b0;
         stat_ovr   <= 1'b0;
      end else begin
         pc_load <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               case (cmd)
                  4'h0: addr <= (addr << 4) | AW'(nib);
                  4'h1: data <= (data << 4) | DW'(nib);
                  4'h2: begin
                     addr <= '0;
                     data <= '0;
                  end
                  4'h8, 4'h9: begin
                     we      <= (cmd == 4'h8);
                     inc     <= nib[0];
                     tmo_cnt <= '0;
                  end
                  4'hA: byte_idx <= '0;
                  4'hB: begin
                     case (nib)
                        4'h0: core_reset <= 1'b0;
                        4'h1: core_reset <= 1'b1;
                        4'h2: core_state <= 2'd0;
                        4'h3: core_state <= 2'd1;
                        4'h4: core_state <= 2'd2;
                        4'h5: pc_load    <= 1'b1;
                        4'h6: data       <= core_pc;
                        4'h7: stat_ovr   <= 1'b0;
                        default: ;
                     endcase
                  end
                  default: ack_byte <= 8'hE0;
               endcase
            end
            BUS: begin
               if (bus_if.bus_ack) begin
                  if (!we) data <= bus_if.bus_rdata;
                  if (inc)  addr <= addr + AW'(1);
                  if (we)   ack_byte <= 8'hA0;
                  else      byte_idx <= '0;
               end else if (timed_out) begin
                  ack_byte <= 8'hE1;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            TX_DATA: if (bus_if.tx_ready && !tx_last) byte_idx <= byte_idx + 4'd1;
            default: ;
         endcase
         // Placed last so an overrun in the same cycle as a clear leaves the flag set.
         if (bus_if.rx_valid && (state != IDLE)) stat_ovr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ice_bridge.sv
// Scoreboard bench for ice_bridge: directed command bytes push expected bus cycles and TX bytes;
// independent monitors pop and compare as the DUT presents them.
module tb_ice_bridge;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
   } bus_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_reset;
   logic [1:0]  core_state;
   logic        pc_load;
   logic [15:0] pc_value;
   logic [15:0] core_pc = 16'h0000;
   logic        stat_ovr;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  tx_q[$];
   bus_exp_t    bus_q[$];

   int          ack_at = 0;
   logic [15:0] rdata_val = 16'h0000;
   int          req_cnt = 0;
   int          last_req_len = 0;

   ice_bridge_if #(.AW(16), .DW(16)) bif ();

   ice_bridge #(.AW(16), .DW(16), .TIMEOUT(255)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus_if     (bif),
      .core_reset (core_reset),
      .core_state (core_state),
      .pc_load    (pc_load),
      .pc_value   (pc_value),
      .core_pc    (core_pc),
      .stat_ovr   (stat_ovr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // TX monitor: every transferred byte must be the next one expected.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bif.tx_valid && bif.tx_ready) begin
            if (tx_q.size() == 0) check("tx_unexpected", {24'h0, bif.tx_data}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'h0, bif.tx_data}, {24'h0, tx_q.pop_front()});
         end
      end
   end

   // Bus responder and monitor: compares the request, tracks stability and length, acks on cycle ack_at.
   initial begin
      bus_exp_t    e;
      logic [15:0] f_addr, f_wdata;
      logic        f_we;
      int          unstable;
      unstable = 0;
      f_addr = '0; f_wdata = '0; f_we = 1'b0;
      forever begin
         @(negedge clk);
         bif.bus_ack = 1'b0;
         if (bif.bus_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
               f_addr = bif.bus_addr; f_we = bif.bus_we; f_wdata = bif.bus_wdata;
               if (bus_q.size() == 0) check("bus_unexpected", {16'h0, bif.bus_addr}, 32'hFFFF_FFFF);
               else begin
                  e = bus_q.pop_front();
                  check("bus_addr", {16'h0, bif.bus_addr}, {16'h0, e.addr});
                  check("bus_we", {31'h0, bif.bus_we}, {31'h0, e.we});
                  if (e.we) check("bus_wdata", {16'h0, bif.bus_wdata}, {16'h0, e.wdata});
               end
            end else if (bif.bus_addr !== f_addr || bif.bus_we !== f_we || bif.bus_wdata !== f_wdata) begin
               unstable = 1;
            end
            if (ack_at != 0 && req_cnt == ack_at) begin
               bif.bus_ack   = 1'b1;
               bif.bus_rdata = rdata_val;
            end
         end else begin
            if (req_cnt != 0) begin
               last_req_len = req_cnt;
               check("bus_stable", unstable, 0);
            end
            req_cnt  = 0;
            unstable = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      while (!bif.rx_ready && n < 2000) begin
         step();
         n++;
      end
      check("send_ready", {31'h0, bif.rx_ready}, 32'h1);
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      step();
      bif.rx_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(tx_q.size() == 0 && bus_q.size() == 0 && bif.rx_ready) && n < 2000) begin
         step();
         n++;
      end
      check("wait_done", n, (n < 2000) ? n : 0);
   endtask

   initial begin
      int stall_bad;
      bif.rx_data = 8'h00; bif.rx_valid = 1'b0; bif.tx_ready = 1'b1;
      bif.bus_ack = 1'b0;  bif.bus_rdata = 16'h0000;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_bus_req", {31'h0, bif.bus_req}, 0);
      check("rst_tx_valid", {31'h0, bif.tx_valid}, 0);
      check("rst_tx_data", {24'h0, bif.tx_data}, 0);
      check("rst_core_reset", {31'h0, core_reset}, 1);
      check("rst_core_state", {30'h0, core_state}, 0);
      check("rst_pc_load", {31'h0, pc_load}, 0);
      check("rst_stat_ovr", {31'h0, stat_ovr}, 0);
      check("rst_addr", {16'h0, bif.bus_addr}, 0);
      check("rst_data", {16'h0, pc_value}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rx_ready", {31'h0, bif.rx_ready}, 1);

      // Write 0xBEEF to 0x1234, ack on third request cycle
      foreach (tx_q[i]) tx_q.delete(i);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h1B); send(8'h1E); send(8'h1E); send(8'h1F);
      bus_q.push_back('{addr: 16'h1234, we: 1'b1, wdata: 16'hBEEF});
      tx_q.push_back(8'hA0);
      ack_at = 3;
      send(8'h80);
      @(negedge clk);
      check("wr_latency", {31'h0, bif.bus_req}, 1);
      wait_done();
      check("wr_req_len", last_req_len, 3);
      check("wr_addr_kept", {16'h0, bif.bus_addr}, 32'h1234);

      // Read with post-increment from 0xFFFF, wraps to 0
      send(8'h20);
      send(8'h0F); send(8'h0F); send(8'h0F); send(8'h0F);
      rdata_val = 16'hCAFE;
      ack_at = 1;
      bus_q.push_back('{addr: 16'hFFFF, we: 1'b0, wdata: 16'h0000});
      tx_q.push_back(8'h5C); tx_q.push_back(8'h5A); tx_q.push_back(8'h5F); tx_q.push_back(8'h5E);
      send(8'h91);
      wait_done();
      check("rd_addr_wrap", {16'h0, bif.bus_addr}, 0);
      check("rd_data", {16'h0, pc_value}, 32'hCAFE);

      // Timeout: no ack ever
      ack_at = 0;
      bus_q.push_back('{addr: 16'h0000, we: 1'b1, wdata: 16'hCAFE});
      tx_q.push_back(8'hE1);
      send(8'h80);
      wait_done();
      check("tmo_req_len", last_req_len, 255);
      check("tmo_addr", {16'h0, bif.bus_addr}, 0);
      check("tmo_data", {16'h0, pc_value}, 32'hCAFE);

      // Core controls
      send(8'hB0);
      @(negedge clk);
      check("core_reset_clr", {31'h0, core_reset}, 0);
      send(8'hB4);
      @(negedge clk);
      check("core_state_2", {30'h0, core_state}, 2);
      send(8'h20);
      send(8'h11);
      send(8'hB5);
      @(negedge clk);
      check("pc_load_hi", {31'h0, pc_load}, 1);
      check("pc_value", {16'h0, pc_value}, 32'h0001);
      @(negedge clk);
      check("pc_load_lo", {31'h0, pc_load}, 0);
      send(8'hB1);
      @(negedge clk);
      check("core_reset_set", {31'h0, core_reset}, 1);
      core_pc = 16'h4321;
      send(8'hB6);
      @(negedge clk);
      check("data_from_pc", {16'h0, pc_value}, 32'h4321);
      tx_q.push_back(8'hE0);
      send(8'h70);
      wait_done();

      // Stalled dump with an overrun byte during the stall
      bif.tx_ready = 1'b0;
      tx_q.push_back(8'h54); tx_q.push_back(8'h53); tx_q.push_back(8'h52); tx_q.push_back(8'h51);
      send(8'hA0);
      @(negedge clk);
      check("stall_first", {23'h0, bif.tx_valid, bif.tx_data}, 32'h154);
      stall_bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 3) begin
            bif.rx_data  = 8'h01;
            bif.rx_valid = 1'b1;
         end else begin
            bif.rx_valid = 1'b0;
         end
         @(negedge clk);
         if (bif.tx_valid !== 1'b1 || bif.tx_data !== 8'h54) stall_bad++;
      end
      check("stall_stable", stall_bad, 0);
      check("ovr_set", {31'h0, stat_ovr}, 1);
      step();
      bif.tx_ready = 1'b1;
      wait_done();
      check("ovr_sticky", {31'h0, stat_ovr}, 1);
      check("ovr_byte_dropped", {16'h0, bif.bus_addr}, 0);
      send(8'hB7);
      @(negedge clk);
      check("ovr_clr", {31'h0, stat_ovr}, 0);

      // Reset in the middle of a read
      send(8'hB0);
      ack_at = 0;
      bus_q.push_back('{addr: 16'h0000, we: 1'b0, wdata: 16'h0000});
      send(8'h90);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_bus_req", {31'h0, bif.bus_req}, 0);
      check("midrst_tx_valid", {31'h0, bif.tx_valid}, 0);
      check("midrst_core_reset", {31'h0, core_reset}, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rx_ready", {31'h0, bif.rx_ready}, 1);
      repeat (3) @(negedge clk);
      check("post_rst_idle", {30'h0, bif.bus_req, bif.tx_valid}, 0);

      check("tx_q_empty", tx_q.size(), 0);
      check("bus_q_empty", bus_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
